// File: rtl/ram_responder.sv
// ram_responder: memory-side partner of the MDR. It services read and write
// requests from the control unit against an internal synchronous RAM array.
// Programmable wait states are inserted before each access.
// Reads drive busRAM and pulse mdr_en. Writes capture busDATA_OUT into the array.
// Build option: define MEM_ERR_EN to add the mem_err output. With it, contention
// (mem_rd and mem_wr both high) and out-of-range addresses are flagged as errors
// instead of being serviced.
module ram_responder #(
    parameter int MAX_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclr,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [MAX_WIDTH-1:0]  busDATA_OUT,
    output logic [MAX_WIDTH-1:0]  busRAM,
    output logic                  mdr_en,
    output logic                  mem_busy,
    output logic                  mem_done
`ifdef MEM_ERR_EN
    ,
    output logic                  mem_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // DEPTH is widened by one bit so that the range check stays a real
    // comparison when DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [MAX_WIDTH-1:0]    data_q;
    logic                    op_wr_q;
`ifdef MEM_ERR_EN
    logic                    both_q;
`endif
    logic [MAX_WIDTH-1:0]    mem [DEPTH];

    logic                    in_range;
    logic                    req_err;
    logic                    wr_en;

    // Decode the latched request: range check, error condition and array write enable.
    always_comb begin
        in_range = ({1'b0, addr_q} < DEPTH_X);
`ifdef MEM_ERR_EN
        req_err  = both_q || !in_range;
`else
        req_err  = 1'b0;
`endif
        // rst/sclr at the ACCESS edge aborts the write as well as the controller.
        wr_en    = (state == S_ACCESS) && op_wr_q && in_range && !req_err
                   && !rst && !sclr;
    end

    // Storage array. It has no reset, so its contents survive rst and sclr.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_q] <= data_q;
        end
    end

    // Controller FSM with registered outputs. rst and sclr both return it to IDLE.
    always_ff @(posedge clk) begin
        if (rst || sclr) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            busRAM   <= '0;
            mdr_en   <= 1'b0;
            mem_busy <= 1'b0;
            mem_done <= 1'b0;
`ifdef MEM_ERR_EN
            mem_err  <= 1'b0;
`endif
        end else begin
            mdr_en   <= 1'b0;
            mem_done <= 1'b0;
`ifdef MEM_ERR_EN
            mem_err  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (mem_rd || mem_wr) begin
                        addr_q   <= addr;
                        data_q   <= busDATA_OUT;
                        // Contention resolves to a read.
                        op_wr_q  <= !mem_rd;
`ifdef MEM_ERR_EN
                        both_q   <= mem_rd && mem_wr;
`endif
                        wait_cnt <= 4'(WAIT_STATES);
                        state    <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                        mem_busy <= 1'b1;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // A read outside the array returns zero. Errored requests leave busRAM alone.
                    if (!op_wr_q && !req_err) begin
                        busRAM <= in_range ? mem[addr_q] : '0;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    mem_done <= 1'b1;
                    mdr_en   <= !op_wr_q && !req_err;
`ifdef MEM_ERR_EN
                    mem_err  <= req_err;
`endif
                    mem_busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    mem_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
